// File: rtl/sqrt_pkg.sv
// Shared types and constants for the square-root bus sequencer.
package sqrt_pkg;

  // Sequencer states; all eight 3-bit encodings are assigned.
  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    LOAD_SQ  = 3'b001,
    INIT_K   = 3'b010,
    INIT_CNT = 3'b011,
    SUB      = 3'b100,
    INC      = 3'b101,
    STEP_K   = 3'b110,
    DONE     = 3'b111
  } state_t;

  // ALU function codes.
  localparam logic [2:0] FN_PASS = 3'b000;  // x
  localparam logic [2:0] FN_ZERO = 3'b001;  // 0
  localparam logic [2:0] FN_ONE  = 3'b010;  // 1
  localparam logic [2:0] FN_INC  = 3'b011;  // x + 1
  localparam logic [2:0] FN_SUB  = 3'b100;  // x - y
  localparam logic [2:0] FN_ADD2 = 3'b101;  // y + 2

  // Per-cycle datapath control vector.
  typedef struct packed {
    logic       trans_sw;
    logic       trans_sq;
    logic       trans_count;
    logic       trans_k;
    logic       ld_sq;
    logic       ld_k;
    logic       ld_count;
    logic [2:0] func;
  } ctrl_t;

endpackage

// File: rtl/sqrt_ctrl_decode.sv
// Pure state-to-control decode (Moore outputs of the sequencer).
module sqrt_ctrl_decode
  import sqrt_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  // Map each state to its transfer enables, load strobes and ALU op.
  always_comb begin
    o_ctrl      = '0;
    o_ctrl.func = FN_PASS;
    case (i_state)
      LOAD_SQ: begin
        o_ctrl.trans_sw = 1'b1;
        o_ctrl.func     = FN_PASS;
        o_ctrl.ld_sq    = 1'b1;
      end
      INIT_K: begin
        o_ctrl.func = FN_ONE;
        o_ctrl.ld_k = 1'b1;
      end
      INIT_CNT: begin
        o_ctrl.func     = FN_ZERO;
        o_ctrl.ld_count = 1'b1;
      end
      SUB: begin
        // ld_sq is gated by the borrow in the top level.
        o_ctrl.trans_sq = 1'b1;
        o_ctrl.trans_k  = 1'b1;
        o_ctrl.func     = FN_SUB;
        o_ctrl.ld_sq    = 1'b1;
      end
      INC: begin
        o_ctrl.trans_count = 1'b1;
        o_ctrl.func        = FN_INC;
        o_ctrl.ld_count    = 1'b1;
      end
      STEP_K: begin
        o_ctrl.trans_k = 1'b1;
        o_ctrl.func    = FN_ADD2;
        o_ctrl.ld_k    = 1'b1;
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/sqrt_bus_sequencer.sv
// Moore sequencer computing floor(sqrt(SW)) on a shared-bus datapath by
// subtracting successive odd numbers, with go/done handshake and an
// iteration guard that aborts with err after MAX_ITER subtract steps.
module sqrt_bus_sequencer
  import sqrt_pkg::*;
#(
  parameter int MAX_ITER = 16,
  parameter int ITER_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              over,
  output logic              trans_sw,
  output logic              trans_sq,
  output logic              trans_count,
  output logic              trans_k,
  output logic              ld_sq,
  output logic              ld_k,
  output logic              ld_count,
  output logic [2:0]        func,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter
);

  localparam logic [ITER_W-1:0] LP_MAX = ITER_W'(MAX_ITER);

  state_t             r_state;
  state_t             w_next;
  logic [ITER_W-1:0]  r_iter;
  logic               r_err;
  logic               w_last;
  logic               w_borrow;
  ctrl_t              w_ctrl;

  // The SUB step that brings the count to MAX_ITER is the last allowed.
  assign w_last   = ((r_iter + ITER_W'(1)) == LP_MAX);
  assign w_borrow = (r_state == SUB) && over;

  // Control decode from state only.
  sqrt_ctrl_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (go) w_next = LOAD_SQ;
      LOAD_SQ:  w_next = INIT_K;
      INIT_K:   w_next = INIT_CNT;
      INIT_CNT: w_next = SUB;
      SUB: begin
        if (over)        w_next = DONE;
        else if (w_last) w_next = DONE;
        else             w_next = INC;
      end
      INC:      w_next = STEP_K;
      STEP_K:   w_next = SUB;
      DONE:     if (!go) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // State, iteration counter and guard flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_iter  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && go) begin
        r_iter <= '0;
      end else if (r_state == SUB && r_iter != LP_MAX) begin
        r_iter <= r_iter + ITER_W'(1);
      end
      if (r_state == SUB) begin
        r_err <= !over && w_last;
      end else if (r_state == DONE && !go) begin
        r_err <= 1'b0;
      end
    end
  end

  assign trans_sw    = w_ctrl.trans_sw;
  assign trans_sq    = w_ctrl.trans_sq;
  assign trans_count = w_ctrl.trans_count;
  assign trans_k     = w_ctrl.trans_k;
  // A borrowing subtract leaves sq holding the remainder.
  assign ld_sq       = w_ctrl.ld_sq & ~w_borrow;
  assign ld_k        = w_ctrl.ld_k;
  assign ld_count    = w_ctrl.ld_count;
  assign func        = w_ctrl.func;
  assign busy        = (r_state != IDLE) && (r_state != DONE);
  assign done        = (r_state == DONE);
  assign err         = r_err;
  assign iter        = r_iter;

endmodule
